// File: rtl/cnn_layer_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM state encoding,
// default parameter values and the stride-2 output-position helper.
package cnn_layer_seq_pkg;

    localparam int W_SIZE_DEF    = 12;
    localparam int W_CHANNEL_DEF = 8;
    localparam int W_DRAIN_DEF   = 4;
    localparam int DRAIN_CYC_DEF = 6;

    // 3-bit state encoding kept as plain constants so older code can share it
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CSYNC = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_PSYNC = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // With stride 2 only even row / even col positions produce an output pixel
    function automatic logic stride_hit(input logic stride2, input logic row_lsb, input logic col_lsb);
        return (!stride2) || ((row_lsb == 1'b0) && (col_lsb == 1'b0));
    endfunction

endpackage

// File: rtl/cnn_layer_seq_loop_cnt.sv
// Three-level nested position counter (col fastest, then chn, then row).
// Each enabled cycle is one beat; wrap happens only at the latched limits.
module cnn_layer_seq_loop_cnt
    import cnn_layer_seq_pkg::*;
#(
    parameter int W_SIZE    = W_SIZE_DEF,
    parameter int W_CHANNEL = W_CHANNEL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [W_SIZE-1:0]    width,
    input  logic [W_SIZE-1:0]    height,
    input  logic [W_CHANNEL-1:0] channel,
    output logic [W_SIZE-1:0]    col,
    output logic [W_SIZE-1:0]    row,
    output logic [W_CHANNEL-1:0] chn,
    output logic                 last_col,
    output logic                 last_row,
    output logic                 last_chn,
    output logic                 frame_end
);

    logic [W_SIZE-1:0]    col_r;
    logic [W_SIZE-1:0]    row_r;
    logic [W_CHANNEL-1:0] chn_r;

    assign last_col  = (col_r == (width   - W_SIZE'(1)));
    assign last_row  = (row_r == (height  - W_SIZE'(1)));
    assign last_chn  = (chn_r == (channel - W_CHANNEL'(1)));
    assign frame_end = en && last_col && last_chn && last_row;
    assign col = col_r;
    assign row = row_r;
    assign chn = chn_r;

    // Advance col, carrying into chn and then row; the final beat clears all three
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
            chn_r <= '0;
        end else if (clr) begin
            col_r <= '0;
            row_r <= '0;
            chn_r <= '0;
        end else if (en) begin
            if (last_col) begin
                col_r <= '0;
                if (last_chn) begin
                    chn_r <= '0;
                    if (last_row) begin
                        row_r <= '0;
                    end else begin
                        row_r <= row_r + W_SIZE'(1);
                    end
                end else begin
                    chn_r <= chn_r + W_CHANNEL'(1);
                end
            end else begin
                col_r <= col_r + W_SIZE'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer: walks one layer per output-channel tile through
// LOAD -> CSYNC -> DATA -> DRAIN, then PSYNC and a one-cycle done pulse.
module cnn_layer_seq
    import cnn_layer_seq_pkg::*;
#(
    parameter int W_SIZE    = W_SIZE_DEF,
    parameter int W_CHANNEL = W_CHANNEL_DEF,
    parameter int W_DRAIN   = W_DRAIN_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    input  logic [W_CHANNEL-1:0] q_channel_out,
    input  logic                 q_stride2,
    input  logic                 q_start,
    input  logic                 i_stall,
    input  logic                 fb_load_ack,
    input  logic                 pe_csync_done,
    input  logic                 pb_sync_done,
    output logic                 o_busy,
    output logic                 o_fb_load_req,
    output logic                 o_ctrl_csync_run,
    output logic                 o_ctrl_data_run,
    output logic                 o_ctrl_psync_run,
    output logic                 o_out_valid,
    output logic                 o_layer_done,
    output logic                 o_is_first_row,
    output logic                 o_is_last_row,
    output logic                 o_is_first_col,
    output logic                 o_is_last_col,
    output logic                 o_is_first_chn,
    output logic                 o_is_last_chn,
    output logic [W_SIZE-1:0]    o_row,
    output logic [W_SIZE-1:0]    o_col,
    output logic [W_CHANNEL-1:0] o_chn,
    output logic [W_CHANNEL-1:0] o_chn_out
);

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [W_SIZE-1:0]    width_r;
    logic [W_SIZE-1:0]    height_r;
    logic [W_CHANNEL-1:0] channel_r;
    logic [W_CHANNEL-1:0] channel_out_r;
    logic                 stride2_r;
    logic [W_DRAIN-1:0]   drain_r;
    logic [W_CHANNEL-1:0] chn_out_r;
    logic [W_SIZE-1:0]    row_s;
    logic [W_SIZE-1:0]    col_s;
    logic [W_CHANNEL-1:0] chn_s;
    logic                 last_col_s;
    logic                 last_row_s;
    logic                 last_chn_s;
    logic                 frame_end_s;
    logic                 beat_s;
    logic                 start_s;
    logic                 cfg_zero_s;
    logic                 last_cout_s;
    logic                 drain_end_s;

    assign start_s     = (state_r == ST_IDLE) && q_start;
    assign beat_s      = (state_r == ST_DATA) && !i_stall;
    assign cfg_zero_s  = (q_width == '0) || (q_height == '0) ||
                         (q_channel == '0) || (q_channel_out == '0);
    assign last_cout_s = (chn_out_r == (channel_out_r - W_CHANNEL'(1)));
    assign drain_end_s = (state_r == ST_DRAIN) && (drain_r == W_DRAIN'(1));

    cnn_layer_seq_loop_cnt #(
        .W_SIZE    (W_SIZE),
        .W_CHANNEL (W_CHANNEL)
    ) u_loop_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (beat_s),
        .clr       (start_s),
        .width     (width_r),
        .height    (height_r),
        .channel   (channel_r),
        .col       (col_s),
        .row       (row_s),
        .chn       (chn_s),
        .last_col  (last_col_s),
        .last_row  (last_row_s),
        .last_chn  (last_chn_s),
        .frame_end (frame_end_s)
    );

    // Next-state decode; handshakes are only looked at in their own state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (q_start) begin
                    state_nxt_s = cfg_zero_s ? ST_DONE : ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (fb_load_ack) begin
                    state_nxt_s = ST_CSYNC;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CSYNC: begin
                if (pe_csync_done) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_CSYNC;
                end
            end
            ST_DATA: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DRAIN: begin
                if (drain_r == W_DRAIN'(1)) begin
                    state_nxt_s = last_cout_s ? ST_PSYNC : ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_PSYNC: begin
                if (pb_sync_done) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PSYNC;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shadow copy of the layer configuration, captured only on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_r       <= '0;
            height_r      <= '0;
            channel_r     <= '0;
            channel_out_r <= '0;
            stride2_r     <= 1'b0;
        end else if (start_s) begin
            width_r       <= q_width;
            height_r      <= q_height;
            channel_r     <= q_channel;
            channel_out_r <= q_channel_out;
            stride2_r     <= q_stride2;
        end
    end

    // Drain countdown after the last beat of a tile, and the output-channel tile index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_r   <= '0;
            chn_out_r <= '0;
        end else begin
            if (frame_end_s) begin
                drain_r <= W_DRAIN'(DRAIN_CYC);
            end else if ((state_r == ST_DRAIN) && (drain_r != '0)) begin
                drain_r <= drain_r - W_DRAIN'(1);
            end
            if (start_s) begin
                chn_out_r <= '0;
            end else if (drain_end_s) begin
                chn_out_r <= last_cout_s ? '0 : (chn_out_r + W_CHANNEL'(1));
            end
        end
    end

    assign o_busy           = (state_r != ST_IDLE);
    assign o_fb_load_req    = (state_r == ST_LOAD);
    assign o_ctrl_csync_run = (state_r == ST_CSYNC);
    assign o_ctrl_data_run  = beat_s;
    assign o_ctrl_psync_run = (state_r == ST_PSYNC);
    assign o_layer_done     = (state_r == ST_DONE);
    assign o_out_valid      = beat_s && stride_hit(stride2_r, row_s[0], col_s[0]);
    assign o_is_first_row   = (row_s == '0);
    assign o_is_first_col   = (col_s == '0);
    assign o_is_first_chn   = (chn_s == '0);
    assign o_is_last_row    = last_row_s;
    assign o_is_last_col    = last_col_s;
    assign o_is_last_chn    = last_chn_s;
    assign o_row            = row_s;
    assign o_col            = col_s;
    assign o_chn            = chn_s;
    assign o_chn_out        = chn_out_r;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Self-checking bench for cnn_layer_seq: table of layer configurations
// plus randomized ones, each checked beat-by-beat against a nested-loop
// model of the expected walk, and a hand-written reset-mid-layer sequence.
module tb_cnn_layer_seq;

    localparam int W_SIZE     = 12;
    localparam int W_CHANNEL  = 8;
    localparam int DRAIN_CYC  = 6;
    localparam int CYC_BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [W_SIZE-1:0]    q_width, q_height;
    logic [W_CHANNEL-1:0] q_channel, q_channel_out;
    logic                 q_stride2, q_start, i_stall;
    logic                 fb_load_ack, pe_csync_done, pb_sync_done;
    logic                 o_busy, o_fb_load_req, o_ctrl_csync_run, o_ctrl_data_run;
    logic                 o_ctrl_psync_run, o_out_valid, o_layer_done;
    logic                 o_is_first_row, o_is_last_row, o_is_first_col;
    logic                 o_is_last_col, o_is_first_chn, o_is_last_chn;
    logic [W_SIZE-1:0]    o_row, o_col;
    logic [W_CHANNEL-1:0] o_chn, o_chn_out;

    always #5 clk = ~clk;

    cnn_layer_seq dut (
        .clk(clk), .rst(rst),
        .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
        .q_channel_out(q_channel_out), .q_stride2(q_stride2), .q_start(q_start),
        .i_stall(i_stall), .fb_load_ack(fb_load_ack),
        .pe_csync_done(pe_csync_done), .pb_sync_done(pb_sync_done),
        .o_busy(o_busy), .o_fb_load_req(o_fb_load_req),
        .o_ctrl_csync_run(o_ctrl_csync_run), .o_ctrl_data_run(o_ctrl_data_run),
        .o_ctrl_psync_run(o_ctrl_psync_run), .o_out_valid(o_out_valid),
        .o_layer_done(o_layer_done),
        .o_is_first_row(o_is_first_row), .o_is_last_row(o_is_last_row),
        .o_is_first_col(o_is_first_col), .o_is_last_col(o_is_last_col),
        .o_is_first_chn(o_is_first_chn), .o_is_last_chn(o_is_last_chn),
        .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_chn_out(o_chn_out)
    );

    typedef struct {
        int w; int h; int c; int cout;
        bit s2;
        int stall_mode;   // 0 none, 1 three-cycle stalls at beat 10 and final beat, 2 random
        int ack_delay;
        bit noise;        // spurious handshakes outside their states
        int exp_beats; int exp_valid; int exp_loads;
    } cfg_t;

    typedef struct { int r; int c; int ch; int co; } beat_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ctl"}, {o_busy, o_fb_load_req, o_ctrl_csync_run, o_ctrl_data_run,
                              o_ctrl_psync_run, o_out_valid, o_layer_done}, 0);
        check({tag, " pos"}, {o_row, o_col, o_chn, o_chn_out}, 0);
        check({tag, " first"}, {o_is_first_row, o_is_first_col, o_is_first_chn}, 7);
        check({tag, " last"}, {o_is_last_row, o_is_last_col, o_is_last_chn}, 0);
    endtask

    // Run one whole layer with a cycle-level responder and a beat scoreboard
    task automatic run_layer(input cfg_t cfg, input string tag);
        beat_t exp_q[$];
        beat_t b;
        int beats = 0, valids = 0, loads = 0, load_cycles = 0, psyncs = 0, dones = 0;
        int done_cyc = -1, cyc = 0, load_wait = 0, stall_left = 0, trig_at = -1;
        int drain_cnt = 0, per_pass;
        bit prev_lr = 1'b0, after_pass = 1'b0, finished = 1'b0, lr, cs, ps;
        per_pass = cfg.w * cfg.h * cfg.c;
        for (int co = 0; co < cfg.cout; co++)
            for (int r = 0; r < cfg.h; r++)
                for (int ch = 0; ch < cfg.c; ch++)
                    for (int c = 0; c < cfg.w; c++) begin
                        b.r = r; b.c = c; b.ch = ch; b.co = co;
                        exp_q.push_back(b);
                    end
        while (!finished && cyc < CYC_BUDGET) begin
            @(negedge clk);
            lr = o_fb_load_req; cs = o_ctrl_csync_run; ps = o_ctrl_psync_run;
            q_start = (cyc == 0) || o_layer_done;
            if (cyc == 0) begin
                q_width = W_SIZE'(cfg.w); q_height = W_SIZE'(cfg.h);
                q_channel = W_CHANNEL'(cfg.c); q_channel_out = W_CHANNEL'(cfg.cout);
                q_stride2 = cfg.s2;
            end else begin
                q_width = W_SIZE'($urandom_range(1, 9)); q_height = W_SIZE'($urandom_range(1, 9));
                q_channel = W_CHANNEL'($urandom_range(1, 9));
                q_channel_out = W_CHANNEL'($urandom_range(1, 9));
                q_stride2 = 1'($urandom_range(0, 1));
            end
            if (lr) load_wait++; else load_wait = 0;
            if (lr) fb_load_ack = (load_wait > cfg.ack_delay);
            else    fb_load_ack = cfg.noise && ($urandom_range(0, 3) == 0);
            if (cs) pe_csync_done = ($urandom_range(0, 1) == 1);
            else    pe_csync_done = cfg.noise && ($urandom_range(0, 3) == 0);
            if (ps) pb_sync_done = ($urandom_range(0, 1) == 1);
            else    pb_sync_done = cfg.noise && ($urandom_range(0, 3) == 0);
            if (stall_left > 0) begin
                i_stall = 1'b1; stall_left--;
            end else if (cfg.stall_mode == 1 && per_pass > 0 && beats != trig_at &&
                         ((beats % per_pass) == 10 || (beats % per_pass) == per_pass - 1)) begin
                i_stall = 1'b1; stall_left = 2; trig_at = beats;
            end else if (cfg.stall_mode == 2) begin
                i_stall = ($urandom_range(0, 2) == 0);
            end else begin
                i_stall = 1'b0;
            end
            #1;
            if (i_stall) check({tag, " stall gates data_run"}, o_ctrl_data_run, 0);
            if (o_ctrl_data_run) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check({tag, " extra beat"}, beats, cfg.exp_beats);
                end else begin
                    b = exp_q.pop_front();
                    check({tag, " row"}, o_row, b.r);
                    check({tag, " col"}, o_col, b.c);
                    check({tag, " chn"}, o_chn, b.ch);
                    check({tag, " chn_out"}, o_chn_out, b.co);
                    check({tag, " flags"},
                          {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col,
                           o_is_first_chn, o_is_last_chn},
                          {b.r == 0, b.r == cfg.h - 1, b.c == 0, b.c == cfg.w - 1,
                           b.ch == 0, b.ch == cfg.c - 1});
                    check({tag, " out_valid"}, o_out_valid,
                          (!cfg.s2) || ((b.r % 2 == 0) && (b.c % 2 == 0)));
                    if (b.r == cfg.h - 1 && b.c == cfg.w - 1 && b.ch == cfg.c - 1) begin
                        after_pass = 1'b1; drain_cnt = 0;
                    end
                end
                if (o_out_valid) valids++;
            end else if (after_pass) begin
                if (lr || ps) begin
                    check({tag, " drain length"}, drain_cnt, DRAIN_CYC);
                    after_pass = 1'b0;
                end else begin
                    drain_cnt++;
                end
            end
            if (lr && !prev_lr) loads++;
            if (lr) load_cycles++;
            prev_lr = lr;
            if (ps) psyncs++;
            if (o_layer_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, " done is one cycle"}, o_layer_done, 0);
                check({tag, " idle after done (start in DONE ignored)"}, o_busy, 0);
                finished = 1'b1;
            end
            cyc++;
        end
        q_start = 1'b0; i_stall = 1'b0;
        fb_load_ack = 1'b0; pe_csync_done = 1'b0; pb_sync_done = 1'b0;
        check({tag, " finished within budget"}, finished, 1);
        check({tag, " data beats"}, beats, cfg.exp_beats);
        check({tag, " out_valid beats"}, valids, cfg.exp_valid);
        check({tag, " load passes"}, loads, cfg.exp_loads);
        check({tag, " load cycles"}, load_cycles, cfg.exp_loads * (cfg.ack_delay + 1));
        check({tag, " done pulses"}, dones, 1);
        check({tag, " psync seen"}, psyncs > 0, cfg.exp_beats > 0);
        check({tag, " beats left over"}, exp_q.size(), 0);
        if (cfg.exp_beats == 0) check({tag, " done latency"}, done_cyc, 1);
    endtask

    // Start a layer, assert reset after 7 beats, then confirm a clean restart
    task automatic reset_mid_layer();
        int beats = 0, cyc = 0;
        @(negedge clk);
        q_width = 12'd4; q_height = 12'd3; q_channel = 8'd2; q_channel_out = 8'd2;
        q_stride2 = 1'b0; q_start = 1'b1;
        while (beats < 7 && cyc < 200) begin
            @(negedge clk);
            q_start = 1'b0; i_stall = 1'b0;
            fb_load_ack = o_fb_load_req; pe_csync_done = o_ctrl_csync_run;
            #1;
            if (o_ctrl_data_run) beats++;
            cyc++;
        end
        check("rst-mid beats reached", beats, 7);
        #1 rst = 1'b1;
        #1 check_idle("rst-mid async");
        @(negedge clk);
        #1 check_idle("rst-mid held");
        rst = 1'b0;
        fb_load_ack = 1'b0; pe_csync_done = 1'b0;
        @(negedge clk);
        #1 check_idle("rst-mid released");
    endtask

    cfg_t tbl[7];
    cfg_t rc;

    initial begin
        rst = 1'b0;
        q_width = '0; q_height = '0; q_channel = '0; q_channel_out = '0;
        q_stride2 = 1'b0; q_start = 1'b0; i_stall = 1'b0;
        fb_load_ack = 1'b0; pe_csync_done = 1'b0; pb_sync_done = 1'b0;
        #2 rst = 1'b1;
        #1 check_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //            w  h  c  co s2    stall dly noise  beats valid loads
        tbl[0] = '{4, 3, 2, 2, 1'b0, 0, 0, 1'b0, 48, 48, 2};
        tbl[1] = '{4, 3, 2, 2, 1'b0, 1, 0, 1'b0, 48, 48, 2};
        tbl[2] = '{4, 4, 1, 1, 1'b1, 0, 0, 1'b0, 16, 4, 1};
        tbl[3] = '{4, 3, 0, 2, 1'b0, 0, 0, 1'b0, 0, 0, 0};
        tbl[4] = '{3, 2, 2, 2, 1'b0, 0, 5, 1'b1, 24, 24, 2};
        tbl[5] = '{5, 3, 3, 2, 1'b1, 2, 1, 1'b1, 90, 36, 2};
        tbl[6] = '{1, 1, 1, 1, 1'b0, 0, 0, 1'b0, 1, 1, 1};
        for (int i = 0; i < 7; i++) run_layer(tbl[i], $sformatf("tbl%0d", i));

        for (int k = 0; k < 3; k++) begin
            rc.w = $urandom_range(1, 5); rc.h = $urandom_range(1, 4);
            rc.c = $urandom_range(1, 3); rc.cout = $urandom_range(1, 3);
            rc.s2 = 1'($urandom_range(0, 1)); rc.stall_mode = 2;
            rc.ack_delay = $urandom_range(0, 3); rc.noise = 1'b1;
            rc.exp_beats = rc.w * rc.h * rc.c * rc.cout;
            rc.exp_valid = rc.s2 ? ((rc.h + 1) / 2) * ((rc.w + 1) / 2) * rc.c * rc.cout
                                 : rc.exp_beats;
            rc.exp_loads = rc.cout;
            run_layer(rc, $sformatf("rnd%0d", k));
        end

        reset_mid_layer();
        run_layer(tbl[0], "after-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
